// File: rtl/mem_pkg.sv
// Shared definitions for the TDM memory controller and its per-core port adapters.
// Holds bus widths, slot geometry and the adapter state encoding.
package mem_pkg;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned N_SLOTS = 8;
    localparam int unsigned CNT_W   = 4;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_SLOT = 2'd1;
    localparam logic [1:0] S_RD_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    typedef enum logic [1:0] {
        StIdle     = S_IDLE,
        StWaitSlot = S_WAIT_SLOT,
        StRdWait   = S_RD_WAIT,
        StDone     = S_DONE
    } adapter_state_e;

endpackage

// File: rtl/mem_port_adapter.sv
// Core-side adapter for one slot of the 8-slot TDM memory controller.
// Holds a single core request on the controller port until its slot comes round.
module mem_port_adapter
    import mem_pkg::*;
#(
    parameter int unsigned SLOT_ID = 0,
    parameter int unsigned RD_WAIT = 8
) (
    input  logic              clk16,
    input  logic              rst_n,
    // core side
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    // controller side
    input  logic [SLOT_W-1:0] slot_phase,
    output logic [ADDR_W-1:0] addr_,
    output logic              we_,
    output logic [DATA_W-1:0] dataIN_,
    input  logic [DATA_W-1:0] dataOUT_
);

    if (SLOT_ID >= N_SLOTS) begin : gen_bad_slot_id
        $error("mem_port_adapter: SLOT_ID must be 0..7");
    end
    if (RD_WAIT == 0 || RD_WAIT >= (1 << CNT_W)) begin : gen_bad_rd_wait
        $error("mem_port_adapter: RD_WAIT must be 1..15");
    end

    localparam logic [SLOT_W-1:0] SlotIdL  = SLOT_W'(SLOT_ID);
    localparam logic [CNT_W-1:0]  RdWaitM1 = CNT_W'(RD_WAIT - 1);

    adapter_state_e    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              slot_hit;

    assign slot_hit = (slot_phase == SlotIdL);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    din_d   = wdata_i;
                    state_d = StWaitSlot;
                end
            end
            // Only reachable one edge after the latch, so a latch on our own
            // slot edge waits a full round before issuing.
            StWaitSlot: begin
                if (slot_hit) begin
                    if (we_q) begin
                        we_d    = 1'b0;
                        state_d = StDone;
                    end else begin
                        cnt_d   = RdWaitM1;
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (cnt_q == '0) begin
                    rdata_d = dataOUT_;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs are decoded straight from the state register.
    assign busy_o  = (state_q == StWaitSlot) || (state_q == StRdWait);
    assign done_o  = (state_q == StDone);
    assign rdata_o = rdata_q;
    assign addr_   = addr_q;
    assign we_     = we_q;
    assign dataIN_ = din_q;

endmodule

// File: tb/tb_mem_port_adapter.sv
// Bench for mem_port_adapter: behavioural TDM controller + RAM, timestamp-based
// transaction model checked every cycle, plus directed latency/data checks.
module tb_mem_port_adapter;
  localparam int SLOT = 3;
  localparam int RDW  = 8;

  logic        clk16 = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic [15:0] wdata_i = '0;
  logic        busy_o, done_o;
  logic [15:0] rdata_o;
  logic [2:0]  slot_phase = 3'd0;
  logic [11:0] addr_;
  logic        we_;
  logic [15:0] dataIN_;
  logic [15:0] dataOUT_ = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  logic [15:0] ram  [0:4095];
  logic [15:0] gold [0:4095];

  mem_port_adapter #(.SLOT_ID(SLOT), .RD_WAIT(RDW)) dut (
    .clk16(clk16), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .slot_phase(slot_phase), .addr_(addr_), .we_(we_), .dataIN_(dataIN_),
    .dataOUT_(dataOUT_)
  );

  always #5 clk16 = ~clk16;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = '0;
      gold[i] = '0;
    end
  end

  // Controller + RAM: samples this slot's port on its slot edge.
  always @(posedge clk16) begin
    slot_phase <= slot_phase + 3'd1;
    if (slot_phase == 3'(SLOT)) begin
      if (we_) ram[addr_] <= dataIN_;
      dataOUT_ <= ram[addr_];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: issue edge = first slot edge strictly after the latch
  // edge; completion = issue (write) or issue + RD_WAIT (read).
  int          m_n = 0;
  int          m_st = 0;  // 0 idle, 1 outstanding, 2 completion cycle
  int          m_issue = 0, m_done = 0;
  logic        m_is_wr = 1'b0, m_we = 1'b0;
  logic [11:0] m_addr = '0;
  logic [15:0] m_wd = '0, m_rdata = '0;

  always @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0;
    end else begin
      m_n = m_n + 1;
      case (m_st)
        0: if (req_i) begin
          m_addr  = addr_i;
          m_we    = we_i;
          m_is_wr = we_i;
          m_wd    = wdata_i;
          m_issue = m_n + ((SLOT + 7 - int'(slot_phase)) % 8) + 1;
          m_done  = m_issue + (we_i ? 0 : RDW);
          m_st    = 1;
        end
        1: begin
          if (m_n == m_issue && m_is_wr) begin
            m_we = 1'b0;
            gold[m_addr] = m_wd;
          end
          if (m_n == m_done) begin
            if (!m_is_wr) m_rdata = gold[m_addr];
            m_st = 2;
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk16) begin
    if (chk_en) begin
      chk("busy_o", 32'(busy_o), 32'(m_st == 1));
      chk("done_o", 32'(done_o), 32'(m_st == 2));
      chk("we_", 32'(we_), 32'(m_we));
      chk("addr_", 32'(addr_), 32'(m_addr));
      chk("dataIN_", 32'(dataIN_), 32'(m_wd));
      chk("rdata_o", 32'(rdata_o), 32'(m_rdata));
    end
  end

  task automatic wait_phase(input logic [2:0] p);
    int g = 0;
    do begin
      @(negedge clk16);
      g++;
    end while (slot_phase != p && g < 16);
  endtask

  // Called just after a negedge; returns at the negedge where done_o is seen.
  task automatic do_req(input logic we, input logic [11:0] a, input logic [15:0] d,
                        output int lat, output logic we_seen);
    int k;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    @(posedge clk16);
    @(negedge clk16);
    req_i = 1'b0;
    k = 1;
    we_seen = we_;
    while (!done_o && k < 40) begin
      @(negedge clk16);
      k++;
      we_seen = we_seen | we_;
    end
    if (!done_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: got no done_o, expected done_o within 40 cycles");
      lat = -1;
    end else begin
      lat = k;
    end
  endtask

  int          lat, k;
  logic        ws, done_seen;
  logic [11:0] addrs [8];
  logic [15:0] datas [8];
  logic [15:0] expm  [int];

  initial begin
    repeat (3) @(negedge clk16);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_we", 32'(we_), 32'd0);
    chk("rst_addr", 32'(addr_), 32'd0);
    chk("rst_rdata", 32'(rdata_o), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: write latched at phase 5 issues on phase-3 edge 6 later
    wait_phase(3'd5);
    do_req(1'b1, 12'h010, 16'hBEEF, lat, ws);
    chk("t1_latency", 32'(lat), 32'd7);
    chk("t1_ram", 32'(ram[12'h010]), 32'hBEEF);

    // 2: read-back, latched at phase 0: issue +3, done RD_WAIT+1 after issue
    wait_phase(3'd0);
    do_req(1'b0, 12'h010, 16'h0000, lat, ws);
    chk("t2_latency", 32'(lat), 32'd12);
    chk("t2_rdata", 32'(rdata_o), 32'hBEEF);
    chk("t2_we_low", 32'(ws), 32'd0);

    // 3: latched on own slot edge waits a full round
    wait_phase(3'd3);
    do_req(1'b1, 12'h030, 16'h1234, lat, ws);
    chk("t3_latency", 32'(lat), 32'd9);
    chk("t3_ram", 32'(ram[12'h030]), 32'h1234);

    // 4: second request while busy and during DONE is ignored
    wait_phase(3'd0);
    req_i = 1'b1; we_i = 1'b1; addr_i = 12'h010; wdata_i = 16'h5555;
    @(posedge clk16);
    @(negedge clk16);
    addr_i = 12'h020; wdata_i = 16'hDEAD;
    k = 1;
    while (!done_o && k < 40) begin
      @(negedge clk16);
      k++;
    end
    chk("t4_latency", 32'(k), 32'd4);
    chk("t4_addr_done", 32'(addr_), 32'h010);
    @(negedge clk16);
    req_i = 1'b0;
    chk("t4_busy_after", 32'(busy_o), 32'd0);
    chk("t4_addr_after", 32'(addr_), 32'h010);
    @(negedge clk16);
    chk("t4_ram20", 32'(ram[12'h020]), 32'h0000);
    chk("t4_ram10", 32'(ram[12'h010]), 32'h5555);

    // 5: reset during RD_WAIT
    wait_phase(3'd0);
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h030;
    @(posedge clk16);
    @(negedge clk16);
    req_i = 1'b0;
    repeat (5) @(negedge clk16);
    chk("t5_busy_pre", 32'(busy_o), 32'd1);
    @(posedge clk16);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", 32'(busy_o), 32'd0);
    chk("t5_we_rst", 32'(we_), 32'd0);
    chk("t5_rdata_rst", 32'(rdata_o), 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk16);
      done_seen = done_seen | done_o;
      if (i == 2) rst_n = 1'b1;
    end
    chk("t5_no_done", 32'(done_seen), 32'd0);
    wait_phase(3'd2);
    do_req(1'b0, 12'h030, 16'h0000, lat, ws);
    chk("t5_latency", 32'(lat), 32'd10);
    chk("t5_rdata", 32'(rdata_o), 32'h1234);

    // 6: back-to-back writes then reads, req re-asserted the cycle after done
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 12'($urandom_range(64, 4095));
      datas[i] = 16'($urandom);
    end
    @(negedge clk16);
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, addrs[i], datas[i], lat, ws);
      expm[int'(addrs[i])] = datas[i];
      @(negedge clk16);
      chk("t6_wr_pulse", 32'(done_o), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, addrs[i], 16'h0000, lat, ws);
      chk("t6_rdata", 32'(rdata_o), 32'(expm[int'(addrs[i])]));
      chk("t6_ram", 32'(ram[addrs[i]]), 32'(expm[int'(addrs[i])]));
      @(negedge clk16);
      chk("t6_rd_pulse", 32'(done_o), 32'd0);
    end

    repeat (2) @(negedge clk16);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
